// File: rtl/fifo_modport.sv
// ---------------------------------------------------------------------------
// fifo_modport
// Single-clock synchronous FIFO exposing the Fifo_if signal set.
// Buffers DSIZE-bit words, 2**ASIZE deep, in first-in-first-out order.
//
// Ports:
//   CLK     in   1      single clock, all state updates on the rising edge
//   RST     in   1      synchronous active-high reset
//   WINC    in   1      write request, accepted when WFULL=0
//   WDATA   in   DSIZE  write data, captured on an accepted write
//   RINC    in   1      read request, accepted when REMPTY=0
//   RDATA   out  DSIZE  registered read data, holds when no read is accepted
//   WFULL   out  1      FIFO holds 2**ASIZE words
//   REMPTY  out  1      FIFO holds 0 words
// ---------------------------------------------------------------------------
module fifo_modport #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WINC,
  input  logic [DSIZE-1:0] WDATA,
  input  logic             RINC,
  output logic [DSIZE-1:0] RDATA,
  output logic             WFULL,
  output logic             REMPTY
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             we;
  logic             re;

  // Flags come only from the registered pointers, so they move in the cycle
  // after an accepting edge. The extra pointer bit separates full from empty:
  // equal pointers mean empty, equal index with differing wrap bits means full.
  assign REMPTY = (wptr == rptr);
  assign WFULL  = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) &&
                  (wptr[ASIZE] != rptr[ASIZE]);

  // Requests are gated by the current flags; a write into a full FIFO or a
  // read from an empty one is simply dropped.
  assign we = WINC & ~WFULL;
  assign re = RINC & ~REMPTY;

  // Storage is not reset; reset blocks a same-cycle write so discarded data
  // never lands in the array.
  always_ff @(posedge CLK) begin
    if (!RST && we) begin
      mem[wptr[ASIZE-1:0]] <= WDATA;
    end
  end

  // Pointers and read data register. Pointers wrap naturally modulo
  // 2**(ASIZE+1); RDATA only updates on an accepted read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      RDATA <= '0;
    end else begin
      if (we) begin
        wptr <= wptr + 1'b1;
      end
      if (re) begin
        RDATA <= mem[rptr[ASIZE-1:0]];
        rptr  <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_modport.sv
// ---------------------------------------------------------------------------
// tb_fifo_modport
// Self-checking bench for fifo_modport. A queue-based reference model tracks
// the stored words; after every clock edge the DUT flags and RDATA are
// compared against it.
// ---------------------------------------------------------------------------
module tb_fifo_modport;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;

  logic             CLK;
  logic             RST;
  logic             WINC;
  logic [DSIZE-1:0] WDATA;
  logic             RINC;
  logic [DSIZE-1:0] RDATA;
  logic             WFULL;
  logic             REMPTY;

  int checks   = 0;
  int failures = 0;

  logic [DSIZE-1:0] modelQ [$];
  logic [DSIZE-1:0] modelRdata = '0;

  fifo_modport #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WINC  (WINC),
    .WDATA (WDATA),
    .RINC  (RINC),
    .RDATA (RDATA),
    .WFULL (WFULL),
    .REMPTY(REMPTY)
  );

  // Free-running clock, 10 time units per period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it, and on mismatch counts and reports it
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge,
  // then compare all outputs one time unit after the edge
  task automatic applyStimulus(input logic rst, input logic winc,
                               input logic [DSIZE-1:0] wdata,
                               input logic rinc, input string tag);
    bit wasFull;
    bit wasEmpty;
    RST   = rst;
    WINC  = winc;
    WDATA = wdata;
    RINC  = rinc;
    @(posedge CLK);
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    if (rst) begin
      modelQ.delete();
      modelRdata = '0;
    end else begin
      if (rinc && !wasEmpty) modelRdata = modelQ.pop_front();
      if (winc && !wasFull)  modelQ.push_back(wdata);
    end
    #1;
    checkOutput({tag, ".REMPTY"}, 32'(REMPTY), 32'(modelQ.size() == 0));
    checkOutput({tag, ".WFULL"},  32'(WFULL),  32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".RDATA"},  32'(RDATA),  32'(modelRdata));
  endtask

  initial begin
    RST   = 1'b1;
    WINC  = 1'b1;
    RINC  = 1'b1;
    WDATA = 8'hEE;

    // Reset for two cycles with both requests high
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, "reset0");
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, "reset1");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "idle");

    // Fill with 0x00..0x0F, then a dropped write of 0xAA
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, "fill");
    checkOutput("fullAfterFill", 32'(WFULL), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, "writeWhenFull");

    // Drain all sixteen, then an extra read must hold 0x0F
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "drain");
      checkOutput("drainOrder", 32'(RDATA), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "readWhenEmpty");
    checkOutput("holdLast", 32'(RDATA), 32'h0F);

    // Boundary: empty with both requests -> write only
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1, "emptyBoth");
    checkOutput("emptyBothRdata", 32'(RDATA), 32'h0F);

    // Build to five words, then twenty cycles of simultaneous traffic
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, "midFill");
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b1, 8'h80 + 8'(i), 1'b1, "simul");

    // Boundary: full with both requests -> read only
    while (modelQ.size() < DEPTH)
      applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, "refill");
    applyStimulus(1'b0, 1'b1, 8'hBB, 1'b1, "fullBoth");
    checkOutput("fullBothWfull", 32'(WFULL), 32'd0);

    // Mid-operation reset after seven writes
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "clear");
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, "preReset");
    applyStimulus(1'b1, 1'b1, 8'hCC, 1'b1, "midReset");
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, "write55");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "read55");
    checkOutput("read55Value", 32'(RDATA), 32'h55);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom),
                    8'($urandom), 1'($urandom), "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
